chan_scan_mux: RTL and testbench

CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

---
 rtl/chan_scan_mux_pkg.sv | 20 ++
 rtl/chan_scan_mux_prescaler.sv | 36 +++
 rtl/chan_scan_mux.sv | 75 +++++++
 tb/tb_chan_scan_mux.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/chan_scan_mux_pkg.sv
// Shared definitions for the channel scan mux and the display drivers built on it.
// Holds the mode encoding and a constant-width helper.
package chan_scan_mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

   // Smallest r with 2**r >= n; usable in parameter expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/chan_scan_mux_prescaler.sv
// Dwell prescaler for auto-scan: counts 0..DIV-1 while enabled and pulses tick on DIV-1.
// clr wins over en; the count is kept unchanged while en is low.
module scan_prescaler
   import chan_scan_mux_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   assign tick = en && !clr && (cnt_q == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered channel multiplexer with manual select and timed auto-scan.
// y and cur_sel are loaded from the same next-select, so they always agree.
module chan_scan_mux
   import chan_scan_mux_pkg::*;
#(
   parameter  int NCH = 4,
   parameter  int W   = 1,
   parameter  int DIV = 4,
   localparam int SW  = clog2(NCH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NCH*W-1:0] data,
   input  logic [SW-1:0]   sel,
   input  logic            mode,
   input  logic            hold,
   output logic [W-1:0]    y,
   output logic [SW-1:0]   cur_sel,
   output logic            sel_chg
);

   mode_e         mode_q;
   logic [SW-1:0] cur_sel_q, nxt_sel;
   logic [W-1:0]  y_q, y_d;
   logic          sel_chg_q;
   logic          mode_rise, ps_en, tick;

   // Entering auto restarts the dwell from zero, even while held.
   assign mode_rise = (mode_e'(mode) == MODE_AUTO) && (mode_q == MODE_MANUAL);
   assign ps_en     = (mode_e'(mode) == MODE_AUTO) && !hold && !mode_rise;

   scan_prescaler #(.DIV(DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (ps_en),
      .clr  (mode_rise),
      .tick (tick)
   );

   always_comb begin
      nxt_sel = cur_sel_q;
      if (!hold) begin
         if (mode_e'(mode) == MODE_MANUAL) begin
            nxt_sel = sel;
         end else if (tick) begin
            // >= also pulls a manually loaded out-of-range index back to 0.
            nxt_sel = (32'(cur_sel_q) >= NCH - 1) ? '0 : cur_sel_q + SW'(1);
         end
      end
   end

   always_comb begin
      y_d = '0;
      if (32'(nxt_sel) < NCH) y_d = data[32'(nxt_sel) * W +: W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q    <= MODE_MANUAL;
         cur_sel_q <= '0;
         y_q       <= '0;
         sel_chg_q <= 1'b0;
      end else begin
         mode_q    <= mode_e'(mode);
         cur_sel_q <= nxt_sel;
         y_q       <= y_d;
         sel_chg_q <= (nxt_sel != cur_sel_q);
      end
   end

   assign y       = y_q;
   assign cur_sel = cur_sel_q;
   assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: a NCH=4/W=4/DIV=3 vector table plus NCH=3 and DIV=1 instances
// for wrap-from-out-of-range and continuous-step behaviour.
module tb_chan_scan_mux;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance A: NCH=4, W=4, DIV=3
   logic [15:0] a_data;
   logic [1:0]  a_sel, a_cur;
   logic        a_mode, a_hold, a_chg;
   logic [3:0]  a_y;
   // Instance B: NCH=3, W=4, DIV=3
   logic [11:0] b_data;
   logic [1:0]  b_sel, b_cur;
   logic        b_mode, b_hold, b_chg;
   logic [3:0]  b_y;
   // Instance C: NCH=4, W=4, DIV=1
   logic [15:0] c_data;
   logic [1:0]  c_sel, c_cur;
   logic        c_mode, c_hold, c_chg;
   logic [3:0]  c_y;

   chan_scan_mux #(.NCH(4), .W(4), .DIV(3)) dut_a (
      .clk(clk), .rst(rst), .data(a_data), .sel(a_sel), .mode(a_mode), .hold(a_hold),
      .y(a_y), .cur_sel(a_cur), .sel_chg(a_chg));
   chan_scan_mux #(.NCH(3), .W(4), .DIV(3)) dut_b (
      .clk(clk), .rst(rst), .data(b_data), .sel(b_sel), .mode(b_mode), .hold(b_hold),
      .y(b_y), .cur_sel(b_cur), .sel_chg(b_chg));
   chan_scan_mux #(.NCH(4), .W(4), .DIV(1)) dut_c (
      .clk(clk), .rst(rst), .data(c_data), .sel(c_sel), .mode(c_mode), .hold(c_hold),
      .y(c_y), .cur_sel(c_cur), .sel_chg(c_chg));

   typedef struct {
      logic        mode;
      logic        hold;
      logic [1:0]  sel;
      logic [15:0] data;
      logic [3:0]  y;
      logic [1:0]  cur;
      logic        chg;
   } vec_t;

   vec_t       vecs[$];
   logic [6:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic m, input logic h, input logic [1:0] s,
                               input logic [15:0] d, input logic [3:0] y,
                               input logic [1:0] c, input logic g);
      vec_t v;
      v.mode = m; v.hold = h; v.sel = s; v.data = d; v.y = y; v.cur = c; v.chg = g;
      vecs.push_back(v);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [6:0] got;
      int         exp_c;

      // Table: manual select, auto scan, hold with data change, mode changes under hold.
      add(0,0,2,16'h4321, 4'h3,2,1); add(0,0,2,16'h4321, 4'h3,2,0);
      add(0,0,1,16'h4321, 4'h2,1,1); add(0,0,0,16'h4321, 4'h1,0,1);
      add(1,0,0,16'h4321, 4'h1,0,0); add(1,0,0,16'h4321, 4'h1,0,0);
      add(1,0,0,16'h4321, 4'h1,0,0); add(1,0,0,16'h4321, 4'h2,1,1);
      add(1,0,0,16'h4321, 4'h2,1,0); add(1,0,0,16'h4321, 4'h2,1,0);
      add(1,0,0,16'h4321, 4'h3,2,1); add(1,0,0,16'h4321, 4'h3,2,0);
      add(1,0,0,16'h4321, 4'h3,2,0); add(1,0,0,16'h4321, 4'h4,3,1);
      add(1,0,0,16'h4321, 4'h4,3,0); add(1,0,0,16'h4321, 4'h4,3,0);
      add(1,0,0,16'h4321, 4'h1,0,1); add(1,0,0,16'h4321, 4'h1,0,0);
      add(1,0,0,16'h4321, 4'h1,0,0); add(1,0,0,16'h4321, 4'h2,1,1);
      add(1,0,0,16'h4321, 4'h2,1,0);
      add(1,1,0,16'h4321, 4'h2,1,0); add(1,1,0,16'h43A1, 4'hA,1,0);
      add(1,1,0,16'h43A1, 4'hA,1,0); add(1,1,0,16'h43A1, 4'hA,1,0);
      add(1,1,0,16'h43A1, 4'hA,1,0);
      add(1,0,0,16'h43A1, 4'hA,1,0); add(1,0,0,16'h43A1, 4'h3,2,1);
      add(1,0,0,16'h43A1, 4'h3,2,0);
      add(0,1,0,16'h43A1, 4'h3,2,0); add(1,1,0,16'h43A1, 4'h3,2,0);
      add(1,0,0,16'h43A1, 4'h3,2,0); add(1,0,0,16'h43A1, 4'h3,2,0);
      add(1,0,0,16'h43A1, 4'h4,3,1);
      add(0,0,1,16'h43A1, 4'hA,1,1); add(0,0,1,16'h1234, 4'h3,1,0);
      add(0,0,3,16'h1234, 4'h1,3,1);

      // Reset state
      rst = 1'b1;
      a_data = 16'h4321; a_sel = 2'd0; a_mode = 1'b0; a_hold = 1'b0;
      b_data = 12'h321;  b_sel = 2'd0; b_mode = 1'b0; b_hold = 1'b0;
      c_data = 16'h4321; c_sel = 2'd0; c_mode = 1'b0; c_hold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_y", a_y, 0); check("rst_a_cur", a_cur, 0); check("rst_a_chg", a_chg, 0);
      check("rst_b_cur", b_cur, 0); check("rst_c_cur", c_cur, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         a_mode = vecs[i].mode; a_hold = vecs[i].hold;
         a_sel  = vecs[i].sel;  a_data = vecs[i].data;
         exp_q.push_back({vecs[i].y, vecs[i].cur, vecs[i].chg});
         @(posedge clk);
         #1;
         got = exp_q.pop_front();
         check($sformatf("v%0d_y", i),   a_y,   got[6:3]);
         check($sformatf("v%0d_cur", i), a_cur, got[2:1]);
         check($sformatf("v%0d_chg", i), a_chg, got[0]);
      end

      // Asynchronous reset in the middle of an auto scan at channel 2
      @(negedge clk); a_mode = 1'b0; a_sel = 2'd2;
      @(posedge clk); #1;
      check("pre_y", a_y, 4'h2); check("pre_cur", a_cur, 2); check("pre_chg", a_chg, 1);
      @(negedge clk); a_mode = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      check("scan_cur", a_cur, 2);
      rst = 1'b1;
      #1;
      check("async_y", a_y, 0); check("async_cur", a_cur, 0); check("async_chg", a_chg, 0);
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_cur", a_cur, 0); check("post_chg", a_chg, 0); check("post_y", a_y, 4'h4);
      repeat (3) @(posedge clk);
      #1;
      check("post_step_cur", a_cur, 1); check("post_step_chg", a_chg, 1);
      check("post_step_y", a_y, 4'h3);

      // NCH=3: out-of-range manual index, then auto-scan wraps and stays in range
      @(negedge clk); b_sel = 2'd3;
      @(posedge clk); #1;
      check("b_oor_y", b_y, 0); check("b_oor_cur", b_cur, 3); check("b_oor_chg", b_chg, 1);
      @(negedge clk); b_mode = 1'b1;
      @(posedge clk); #1;
      check("b_rise_cur", b_cur, 3); check("b_rise_chg", b_chg, 0);
      for (int e = 2; e <= 13; e++) begin
         @(posedge clk); #1;
         exp_c = (e < 4) ? 3 : ((e - 4) / 3) % 3;
         check($sformatf("b_e%0d_cur", e), b_cur, exp_c);
         check($sformatf("b_e%0d_y", e), b_y, (exp_c == 3) ? 0 : exp_c + 1);
         check($sformatf("b_e%0d_chg", e), b_chg, (e >= 4 && (e - 4) % 3 == 0) ? 1 : 0);
      end

      // DIV=1: one channel per cycle, sel_chg held high
      @(negedge clk); c_mode = 1'b1;
      @(posedge clk); #1;
      check("c_rise_cur", c_cur, 0); check("c_rise_chg", c_chg, 0);
      for (int k = 2; k <= 9; k++) begin
         @(posedge clk); #1;
         check($sformatf("c_k%0d_cur", k), c_cur, (k - 1) % 4);
         check($sformatf("c_k%0d_y", k), c_y, ((k - 1) % 4) + 1);
         check($sformatf("c_k%0d_chg", k), c_chg, 1);
      end

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
